// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer: latches a taken target, handshakes the redirect to fetch, then drains.
// Optional statistics counters are built when BRANCH_REDIRECT_CTRL_STATS_EN is defined.
module branch_redirect_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ex_valid,
    input  logic                 jack,
    input  logic                 je,
    input  logic [XLEN-1:0]      target_pc,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    input  logic                 redirect_ready,
    output logic                 flush,
    output logic                 ex_stall,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] branch_count,
    output logic [CNT_WIDTH-1:0] taken_count
);

    // state    | meaning
    // IDLE     | waiting for a taken resolution from the JBU
    // REDIRECT | redirect_valid high until fetch accepts it
    // DRAIN    | flushing wrong-path instructions, counter runs down to 0
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYCLES == 0) ? 4'd0 : 4'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              rv_q, rv_d;
    logic              fl_q, fl_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && jack && je) begin
                    pc_d    = {target_pc[XLEN-1:1], 1'b0};
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = DRAIN_LOAD;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // outputs are registered copies of the next-state decode
        rv_d = (state_d == REDIRECT);
        fl_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pc_q    <= '0;
            rv_q    <= 1'b0;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rv_q    <= rv_d;
            fl_q    <= fl_d;
        end
    end

    assign redirect_valid = rv_q;
    assign redirect_pc    = pc_q;
    assign flush          = fl_q;
    assign ex_stall       = fl_q;
    assign busy           = fl_q;

`ifdef BRANCH_REDIRECT_CTRL_STATS_EN
    logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    always_comb begin
        bcnt_d = bcnt_q;
        tcnt_d = tcnt_q;
        if (state_q == IDLE && ex_valid && jack) begin
            bcnt_d = bcnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (je) begin
                tcnt_d = tcnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q <= '0;
            tcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign branch_count = bcnt_q;
    assign taken_count  = tcnt_q;
`else
    assign branch_count = '0;
    assign taken_count  = '0;
`endif

endmodule
